// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the miniRV core: owns the PC, runs the req/gnt/rvalid
// instruction fetch, presents the instruction to decode and commits the
// next-PC result. A missed response or misaligned target halts until reset.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  output logic [31:0]         pc,
  input  logic [31:0]         npc,
  input  logic [1:0]          npc_op,
  input  logic                stall,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         inst,
  output logic                inst_valid,
  output logic                redirect,
  output logic [31:0]         instret,
  output logic                fetch_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = WAIT_TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        redirect_q, redirect_d;
  logic [31:0] instret_q, instret_d;
  logic        fetch_err_q, fetch_err_d;
  logic [7:0]  wcnt_q, wcnt_d;

  // Request is a pure state decode, forced low while reset is held.
  assign imem.imem_req  = (state_q == S_REQ) && !cpu_rst;
  assign imem.imem_addr = pc_q;

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign redirect   = redirect_q;
  assign instret    = instret_q;
  assign fetch_err  = fetch_err_q;

  // Next-state and datapath update for the fetch/commit sequence.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instret_d   = instret_q;
    redirect_d  = 1'b0;
    fetch_err_d = fetch_err_q;
    wcnt_d      = wcnt_q;

    unique case (state_q)
      S_REQ: begin
        // rvalid without gnt is a stale response and is ignored.
        if (imem.imem_gnt) begin
          if (imem.imem_rvalid) begin
            inst_d  = imem.imem_rdata;
            state_d = S_EXEC;
          end else begin
            wcnt_d  = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // rvalid wins over the timeout, so the last allowed cycle still accepts.
        if (imem.imem_rvalid) begin
          inst_d  = imem.imem_rdata;
          state_d = S_EXEC;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_d == WAIT_LIMIT) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          instret_d = instret_q + 32'd1;
          if (npc[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            pc_d       = npc;
            redirect_d = (npc_op == 2'd1) || (npc_op == 2'd2);
            state_d    = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    inst_valid_d = (state_d == S_EXEC);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
      instret_q    <= '0;
      fetch_err_q  <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      redirect_q   <= redirect_d;
      instret_q    <= instret_d;
      fetch_err_q  <= fetch_err_d;
      wcnt_q       <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each task drives one scenario cycle by cycle
// and compares outputs against hand-derived values.
module tb_fetch_ctrl;
  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [1:0]  npc_op;
  logic        stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        redirect;
  logic [31:0] instret;
  logic        fetch_err;

  int unsigned vec  = 0;
  int unsigned errs = 0;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .WAIT_TIMEOUT (255)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .pc         (pc),
    .npc        (npc),
    .npc_op     (npc_op),
    .stall      (stall),
    .imem       (imem_bus),
    .inst       (inst),
    .inst_valid (inst_valid),
    .redirect   (redirect),
    .instret    (instret),
    .fetch_err  (fetch_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    stall = 1'b0;
    npc = '0;
    npc_op = '0;
    tick();
    cpu_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; npc = 32'h4; npc_op = 2'd1;
    #1;
    vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL rst_req_pre: got %b want 0", imem_bus.imem_req); end
    tick();
    vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", imem_bus.imem_req); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL rst_pc: got %h want 0", pc); end
    vec++; if (inst !== 32'h0) begin errs++; $display("FAIL rst_inst: got %h want 0", inst); end
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL rst_redirect: got %b want 0", redirect); end
    vec++; if (instret !== 32'h0) begin errs++; $display("FAIL rst_instret: got %h want 0", instret); end
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL rst_fetch_err: got %b want 0", fetch_err); end
    cpu_rst = 1'b0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    #1;
    vec++; if (imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL rst_release_req: got %b want 1", imem_bus.imem_req); end
    vec++; if (imem_bus.imem_addr !== 32'h0) begin errs++; $display("FAIL rst_release_addr: got %h want 0", imem_bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_pc = 32'(c / 2) * 32'd4;
      vec++; if (pc !== exp_pc) begin errs++; $display("FAIL seq_pc c%0d: got %h want %h", c, pc, exp_pc); end
      vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL seq_redirect c%0d: got %b want 0", c, redirect); end
      vec++; if (instret !== 32'(c / 2)) begin errs++; $display("FAIL seq_instret c%0d: got %h want %h", c, instret, 32'(c / 2)); end
      if (c % 2 == 0) begin
        vec++; if (imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL seq_req c%0d: got %b want 1", c, imem_bus.imem_req); end
        vec++; if (imem_bus.imem_addr !== exp_pc) begin errs++; $display("FAIL seq_addr c%0d: got %h want %h", c, imem_bus.imem_addr, exp_pc); end
        vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL seq_iv c%0d: got %b want 0", c, inst_valid); end
      end else begin
        vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL seq_req c%0d: got %b want 0", c, imem_bus.imem_req); end
        vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL seq_iv c%0d: got %b want 1", c, inst_valid); end
        vec++; if (inst !== 32'h1000_0000 + 32'(c - 1)) begin errs++; $display("FAIL seq_inst c%0d: got %h want %h", c, inst, 32'h1000_0000 + 32'(c - 1)); end
      end
      imem_bus.imem_rdata = 32'h1000_0000 + 32'(c);
      npc = exp_pc + 32'd4;
      npc_op = 2'd0;
      stall = 1'b0;
      tick();
    end
    vec++; if (pc !== 32'h10) begin errs++; $display("FAIL seq_pc_end: got %h want 10", pc); end
    vec++; if (instret !== 32'd4) begin errs++; $display("FAIL seq_instret_end: got %h want 4", instret); end
  endtask

  task automatic test_wait_stall();
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    tick();
    imem_bus.imem_gnt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL wait_req w%0d: got %b want 0", i, imem_bus.imem_req); end
      vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL wait_iv w%0d: got %b want 0", i, inst_valid); end
      imem_bus.imem_rvalid = (i == 3);
      imem_bus.imem_rdata = (i == 3) ? 32'h0050_0093 : 32'hFFFF_FFFF;
      tick();
    end
    imem_bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL stall_iv s%0d: got %b want 1", i, inst_valid); end
      vec++; if (inst !== 32'h0050_0093) begin errs++; $display("FAIL stall_inst s%0d: got %h want 00500093", i, inst); end
      vec++; if (pc !== 32'h0) begin errs++; $display("FAIL stall_pc s%0d: got %h want 0", i, pc); end
      vec++; if (instret !== 32'h0) begin errs++; $display("FAIL stall_instret s%0d: got %h want 0", i, instret); end
      stall = 1'b1; npc = 32'h8; npc_op = 2'd1;
      tick();
    end
    vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL stall_iv5: got %b want 1", inst_valid); end
    stall = 1'b0; npc = 32'h4; npc_op = 2'd0;
    tick();
    vec++; if (pc !== 32'h4) begin errs++; $display("FAIL commit_pc: got %h want 4", pc); end
    vec++; if (instret !== 32'd1) begin errs++; $display("FAIL commit_instret: got %h want 1", instret); end
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL commit_iv: got %b want 0", inst_valid); end
    vec++; if (imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL commit_req: got %b want 1", imem_bus.imem_req); end
    vec++; if (imem_bus.imem_addr !== 32'h4) begin errs++; $display("FAIL commit_addr: got %h want 4", imem_bus.imem_addr); end
    vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL commit_redirect: got %b want 0", redirect); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_006F;
    tick();
    npc = 32'h40; npc_op = 2'd1; stall = 1'b0;
    tick();
    vec++; if (pc !== 32'h40) begin errs++; $display("FAIL redir1_pc: got %h want 40", pc); end
    vec++; if (redirect !== 1'b1) begin errs++; $display("FAIL redir1_pulse: got %b want 1", redirect); end
    vec++; if (imem_bus.imem_addr !== 32'h40) begin errs++; $display("FAIL redir1_addr: got %h want 40", imem_bus.imem_addr); end
    vec++; if (imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL redir1_req: got %b want 1", imem_bus.imem_req); end
    tick();
    vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL redir1_end: got %b want 0", redirect); end
    vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL redir1_iv: got %b want 1", inst_valid); end
    npc = 32'h80; npc_op = 2'd2;
    tick();
    vec++; if (pc !== 32'h80) begin errs++; $display("FAIL redir2_pc: got %h want 80", pc); end
    vec++; if (redirect !== 1'b1) begin errs++; $display("FAIL redir2_pulse: got %b want 1", redirect); end
    tick();
    vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL redir2_end: got %b want 0", redirect); end
    npc = 32'h84; npc_op = 2'd3;
    tick();
    vec++; if (pc !== 32'h84) begin errs++; $display("FAIL redir3_pc: got %h want 84", pc); end
    vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL redir3_pulse: got %b want 0", redirect); end
    vec++; if (instret !== 32'd3) begin errs++; $display("FAIL redir3_instret: got %h want 3", instret); end
  endtask

  task automatic test_timeout_accept();
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    tick();
    imem_bus.imem_gnt = 1'b0;
    for (int w = 1; w <= 255; w++) begin
      if (w == 255) begin
        vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL tacc_err_w255: got %b want 0", fetch_err); end
        vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL tacc_req_w255: got %b want 0", imem_bus.imem_req); end
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata = 32'h0000_0013;
      end
      tick();
    end
    imem_bus.imem_rvalid = 1'b0;
    stall = 1'b1;
    vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL tacc_iv: got %b want 1", inst_valid); end
    vec++; if (inst !== 32'h0000_0013) begin errs++; $display("FAIL tacc_inst: got %h want 13", inst); end
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL tacc_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_timeout_err();
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    tick();
    imem_bus.imem_gnt = 1'b0;
    for (int w = 1; w <= 255; w++) begin
      if (w == 255) begin
        vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL tout_early: got %b want 0", fetch_err); end
      end
      tick();
    end
    vec++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL tout_err: got %b want 1", fetch_err); end
    vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL tout_req: got %b want 0", imem_bus.imem_req); end
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL tout_iv: got %b want 0", inst_valid); end
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL halt_req: got %b want 0", imem_bus.imem_req); end
    vec++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL halt_sticky: got %b want 1", fetch_err); end
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL halt_iv: got %b want 0", inst_valid); end
    do_reset();
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL tout_rst_err: got %b want 0", fetch_err); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL tout_rst_pc: got %h want 0", pc); end
    vec++; if (imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL tout_rst_req: got %b want 1", imem_bus.imem_req); end
  endtask

  task automatic test_misaligned();
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0013;
    tick();
    npc = 32'h8; npc_op = 2'd0; stall = 1'b0;
    tick();
    tick();
    vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL mis_iv_pre: got %b want 1", inst_valid); end
    npc = 32'h6; npc_op = 2'd0;
    tick();
    vec++; if (pc !== 32'h8) begin errs++; $display("FAIL mis_pc: got %h want 8", pc); end
    vec++; if (instret !== 32'd2) begin errs++; $display("FAIL mis_instret: got %h want 2", instret); end
    vec++; if (fetch_err !== 1'b1) begin errs++; $display("FAIL mis_err: got %b want 1", fetch_err); end
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL mis_iv: got %b want 0", inst_valid); end
    vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL mis_req: got %b want 0", imem_bus.imem_req); end
    vec++; if (redirect !== 1'b0) begin errs++; $display("FAIL mis_redirect: got %b want 0", redirect); end
    npc = 32'h10;
    tick();
    vec++; if (pc !== 32'h8) begin errs++; $display("FAIL mis_pc_frozen: got %h want 8", pc); end
    vec++; if (instret !== 32'd2) begin errs++; $display("FAIL mis_instret_frozen: got %h want 2", instret); end
    do_reset();
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL mis_rst_pc: got %h want 0", pc); end
    vec++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL mis_rst_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_stale();
    do_reset();
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    tick();
    cpu_rst = 1'b1;
    imem_bus.imem_gnt = 1'b0;
    #1;
    vec++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL stale_rst_req: got %b want 0", imem_bus.imem_req); end
    tick();
    cpu_rst = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0BAD;
    tick();
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL stale_iv: got %b want 0", inst_valid); end
    vec++; if (inst !== 32'h0) begin errs++; $display("FAIL stale_inst: got %h want 0", inst); end
    vec++; if (imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL stale_req: got %b want 1", imem_bus.imem_req); end
    imem_bus.imem_rvalid = 1'b0;
    tick();
    vec++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL stale_iv2: got %b want 0", inst_valid); end
    imem_bus.imem_gnt = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata = 32'h0010_0113;
    tick();
    vec++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL stale_fetch_iv: got %b want 1", inst_valid); end
    vec++; if (inst !== 32'h0010_0113) begin errs++; $display("FAIL stale_fetch_inst: got %h want 00100113", inst); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL stale_fetch_pc: got %h want 0", pc); end
  endtask

  initial begin
    cpu_rst = 1'b1;
    npc = '0;
    npc_op = '0;
    stall = 1'b0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = '0;
    test_reset();
    test_sequential();
    test_wait_stall();
    test_redirect();
    test_timeout_accept();
    test_timeout_err();
    test_misaligned();
    test_stale();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
